// File: rtl/rcon_seq.sv
// AES round-constant engine: walks Rcon by GF(2^8) doubling and XORs it
// into one byte lane of each key-schedule word, with valid/ready on both sides.
module rcon_seq #(
   parameter int WORD_W    = 32,
   parameter int RCON_BYTE = WORD_W/8-1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        key_size,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [3:0]        out_round,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [3:0]        round_q, round_d;
   logic [3:0]        last_q, last_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic [3:0]        out_round_q, out_round_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q, done_d;
   logic [WORD_W-1:0] rcon_lane;
   logic              accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign rcon_lane = WORD_W'(rcon_q) << (8*RCON_BYTE);

   always_comb begin
      state_d     = state_q;
      rcon_d      = rcon_q;
      round_d     = round_q;
      last_d      = last_q;
      out_word_d  = out_word_q;
      out_round_d = out_round_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      in_ready    = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               case (key_size)
                  2'd1:    last_d = 4'd8;
                  2'd2:    last_d = 4'd7;
                  default: last_d = 4'd10;
               endcase
               rcon_d  = 8'h01;
               round_d = 4'd1;
               state_d = RUN;
            end
         end
         RUN: begin
            in_ready = !out_valid_q || out_ready;
            accept   = in_valid && in_ready;
            if (out_valid_q && out_ready)
               out_valid_d = 1'b0;
            // a load in the same cycle as a drain overrides the clear above
            if (accept) begin
               out_word_d  = in_word ^ rcon_lane;
               out_round_d = round_q;
               out_valid_d = 1'b1;
               rcon_d      = xtime(rcon_q);
               if (round_q == last_q)
                  state_d = FLUSH;
               else
                  round_d = round_q + 4'd1;
            end
         end
         FLUSH: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rcon_q      <= 8'h01;
         round_q     <= 4'd1;
         last_q      <= 4'd10;
         out_word_q  <= '0;
         out_round_q <= 4'd0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rcon_q      <= rcon_d;
         round_q     <= round_d;
         last_q      <= last_d;
         out_word_q  <= out_word_d;
         out_round_q <= out_round_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign out_word  = out_word_q;
   assign out_round = out_round_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);

endmodule
